// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared AES-128 types and GF(2^8) helpers for the key-schedule block.
package aes_key_sched_ctrl_pkg;

  localparam int unsigned AES128_NR = 10;

  typedef logic [127:0] round_key_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [0:0] {StIdle, StExp} ks_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box computed as multiplicative inverse (x^254, maps 0 to 0) plus affine map.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {aes_sbox(w[31:24]), aes_sbox(w[23:16]), aes_sbox(w[15:8]), aes_sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_key_expand_128.sv
// AES-128 key expander: loads the cipher key on kld, then produces one round key per cycle.
module aes_key_expand_128
  import aes_key_sched_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       kld,
  input  round_key_t key,
  output word_t      wo_0,
  output word_t      wo_1,
  output word_t      wo_2,
  output word_t      wo_3
);

  word_t      w0_q, w1_q, w2_q, w3_q;
  word_t      w0_d, w1_d, w2_d, w3_d;
  word_t      temp;
  logic [7:0] rcon_q;

  // Next round key from the current one; rcon_q tracks the round being generated.
  always_comb begin
    temp = sub_word({w3_q[23:0], w3_q[31:24]}) ^ {rcon_q, 24'h0};
    w0_d = w0_q ^ temp;
    w1_d = w1_q ^ w0_d;
    w2_d = w2_q ^ w1_d;
    w3_d = w3_q ^ w2_d;
  end

  // Word registers: load the key, otherwise free-run through the schedule.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w0_q   <= '0;
      w1_q   <= '0;
      w2_q   <= '0;
      w3_q   <= '0;
      rcon_q <= 8'h00;
    end else if (kld) begin
      w0_q   <= key[127:96];
      w1_q   <= key[95:64];
      w2_q   <= key[63:32];
      w3_q   <= key[31:0];
      rcon_q <= 8'h01;
    end else begin
      w0_q   <= w0_d;
      w1_q   <= w1_d;
      w2_q   <= w2_d;
      w3_q   <= w3_d;
      rcon_q <= xtime(rcon_q);
    end
  end

  assign wo_0 = w0_q;
  assign wo_1 = w1_q;
  assign wo_2 = w2_q;
  assign wo_3 = w3_q;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Key-schedule sequencer: loads the expander, captures NR+1 round keys, serves random reads.
module aes_key_sched_ctrl
  import aes_key_sched_ctrl_pkg::*;
#(
  parameter int unsigned NR = AES128_NR,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_vld,
  output logic          key_rdy,
  input  logic [127:0]  key_in,
  input  logic          clr,
  output logic          busy,
  output logic          ks_valid,
  output logic          done,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_vld,
  output logic [127:0]  rd_key,
  output logic          rd_err
);

  localparam logic [AW-1:0] LastCnt = AW'(NR);

  ks_state_e     state_q;
  logic [AW-1:0] cnt_q;
  logic          ks_valid_q;
  logic          done_q;
  logic          load;
  logic          rd_ok;
  round_key_t    exp_key;
  round_key_t    store_q [NR+1];
  logic          rd_vld_q;
  logic          rd_err_q;
  round_key_t    rd_key_q;
  word_t         wo_0, wo_1, wo_2, wo_3;

  aes_key_expand_128 u_expand (
    .clk  (clk),
    .rst  (rst),
    .kld  (load),
    .key  (key_in),
    .wo_0 (wo_0),
    .wo_1 (wo_1),
    .wo_2 (wo_2),
    .wo_3 (wo_3)
  );

  assign exp_key = {wo_0, wo_1, wo_2, wo_3};
  assign key_rdy = (state_q == StIdle);
  assign busy    = (state_q == StExp);
  assign load    = key_vld && key_rdy;
  // Reads are only honoured against a complete, stable schedule.
  assign rd_ok   = ks_valid_q && (state_q == StIdle) && (rd_addr <= LastCnt);

  // Sequencer FSM: handshake, NR+1 capture cycles, then completion pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ks_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A handshake takes priority over clr; both invalidate the store.
          if (load) begin
            state_q    <= StExp;
            cnt_q      <= '0;
            ks_valid_q <= 1'b0;
          end else if (clr) begin
            ks_valid_q <= 1'b0;
          end
        end
        StExp: begin
          if (cnt_q == LastCnt) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ks_valid_q <= 1'b1;
            done_q     <= 1'b1;
          end else if (cnt_q > LastCnt) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Key store capture; contents are hidden behind ks_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if ((state_q == StExp) && (cnt_q <= LastCnt)) begin
      store_q[cnt_q] <= exp_key;
    end
  end

  // Registered read port: one-cycle latency, zero data on error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld_q <= 1'b0;
      rd_err_q <= 1'b0;
      rd_key_q <= '0;
    end else begin
      rd_vld_q <= rd_en;
      if (rd_en) begin
        if (rd_ok) begin
          rd_key_q <= store_q[rd_addr];
          rd_err_q <= 1'b0;
        end else begin
          rd_key_q <= '0;
          rd_err_q <= 1'b1;
        end
      end else begin
        rd_err_q <= 1'b0;
      end
    end
  end

  assign ks_valid = ks_valid_q;
  assign done     = done_q;
  assign rd_vld   = rd_vld_q;
  assign rd_err   = rd_err_q;
  assign rd_key   = rd_key_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: directed keys, scoreboarded read port, timing checks.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_vld = 1'b0;
  logic         key_rdy;
  logic [127:0] key_in = '0;
  logic         clr = 1'b0;
  logic         busy;
  logic         ks_valid;
  logic         done;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_addr = '0;
  logic         rd_vld;
  logic [127:0] rd_key;
  logic         rd_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [128:0] exp_q[$];

  logic [127:0] ka0, ka1, ka10;
  logic [127:0] kb [11];

  aes_key_sched_ctrl #(.NR(10), .AW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .key_vld  (key_vld),
    .key_rdy  (key_rdy),
    .key_in   (key_in),
    .clr      (clr),
    .busy     (busy),
    .ks_valid (ks_valid),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_vld   (rd_vld),
    .rd_key   (rd_key),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one read in the current cycle; rd_en stays high for back-to-back use.
  task automatic rd_issue(input logic [3:0] a, input logic err, input logic [127:0] k);
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back({err, k});
    step;
  endtask

  task automatic rd_stop;
    rd_en = 1'b0;
    step;
  endtask

  // Offer a key and walk the 11 expansion cycles, checking status each cycle.
  task automatic offer_key(input logic [127:0] k, input bit hold, input bit clr_exp,
                           input bit rd_hs, input logic [127:0] hs_exp);
    chk1("key_rdy_idle", key_rdy, 1'b1);
    key_vld = 1'b1;
    key_in  = k;
    if (rd_hs) begin
      rd_en   = 1'b1;
      rd_addr = 4'd10;
      exp_q.push_back({1'b0, hs_exp});
    end
    step;
    rd_en = 1'b0;
    if (hold) key_in = ~k;
    else key_vld = 1'b0;
    chk1("ks_valid_drop", ks_valid, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      chk1("busy_exp", busy, 1'b1);
      chk1("key_rdy_exp", key_rdy, 1'b0);
      chk1("done_early", done, 1'b0);
      clr = (c == 3) && clr_exp;
      if (c == 4) begin
        rd_en   = 1'b1;
        rd_addr = 4'd0;
        exp_q.push_back({1'b1, 128'h0});
      end else begin
        rd_en = 1'b0;
      end
      if (c == 10) key_vld = 1'b0;
      step;
    end
    clr   = 1'b0;
    rd_en = 1'b0;
    chk1("done_pulse", done, 1'b1);
    chk1("ks_valid_set", ks_valid, 1'b1);
    chk1("busy_clear", busy, 1'b0);
    step;
    chk1("done_one_cycle", done, 1'b0);
  endtask

  // Scoreboard monitor: every rd_vld must match the oldest expected response.
  initial begin
    logic [128:0] e;
    forever begin
      @(negedge clk);
      if (rd_vld) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rd_unexpected: got rd_vld=1 want no response (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk1("rd_err", rd_err, e[128]);
          chk("rd_key", rd_key, e[127:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    ka0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ka1   = 128'ha0fafe1788542cb123a339392a6c7605;
    ka10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    kb[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    kb[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    kb[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    kb[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    kb[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    kb[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    kb[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    kb[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    kb[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    kb[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    kb[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    // Reset values
    #12;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ks_valid", ks_valid, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_rd_vld", rd_vld, 1'b0);
    chk1("rst_rd_err", rd_err, 1'b0);
    chk("rst_rd_key", rd_key, 128'h0);
    step;
    rst = 1'b1;
    step;
    chk1("key_rdy_after_rst", key_rdy, 1'b1);

    // FIPS-197 key, with clr asserted during expansion (ignored)
    offer_key(ka0, 1'b0, 1'b1, 1'b0, 128'h0);
    rd_issue(4'd0, 1'b0, ka0);
    rd_issue(4'd1, 1'b0, ka1);
    rd_issue(4'd10, 1'b0, ka10);
    rd_issue(4'd11, 1'b1, 128'h0);
    rd_issue(4'd15, 1'b1, 128'h0);
    rd_stop;

    // Second key with key_vld held through EXP; handshake-cycle read sees old data
    offer_key(kb[0], 1'b1, 1'b0, 1'b1, ka10);
    for (int a = 10; a >= 0; a--) rd_issue(4'(a), 1'b0, kb[a]);
    rd_stop;

    // clr in IDLE invalidates the store
    clr = 1'b1;
    step;
    clr = 1'b0;
    chk1("clr_idle", ks_valid, 1'b0);
    rd_issue(4'd3, 1'b1, 128'h0);
    rd_stop;

    // Reset asserted mid-expansion
    offer_key(ka0, 1'b0, 1'b0, 1'b0, 128'h0);
    key_vld = 1'b1;
    key_in  = kb[0];
    step;
    key_vld = 1'b0;
    repeat (4) step;
    #2 rst = 1'b0;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_ks_valid", ks_valid, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_rd_vld", rd_vld, 1'b0);
    chk1("abort_rd_err", rd_err, 1'b0);
    chk("abort_rd_key", rd_key, 128'h0);
    step;
    rst = 1'b1;
    step;
    rd_issue(4'd0, 1'b1, 128'h0);
    rd_stop;
    offer_key(kb[0], 1'b0, 1'b0, 1'b0, 128'h0);
    rd_issue(4'd0, 1'b0, kb[0]);
    rd_issue(4'd5, 1'b0, kb[5]);
    rd_issue(4'd10, 1'b0, kb[10]);
    rd_stop;

    repeat (3) step;
    chk("scoreboard_drained", 128'(exp_q.size()), 128'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
